code_to_led_decoder: RTL

- Receiving end of the 8-to-3 priority encoder used in the lab: takes the 3-bit index plus its valid flag and turns it back into an 8-LED pattern.
- Load is user-strobed, from a button.
- Two display modes:
  - direct one-hot: the LED at the decoded position lights;
  - animated bar-graph sweep: LEDs 0..code fill in one per tick.
- Sits between the encoder outputs (or switches) and the nvboard LED bank.

---
 rtl/code_to_led_decoder.sv | 87 ++++++++
 1 files changed

// File: rtl/code_to_led_decoder.sv
// rtl/code_to_led_decoder.sv - turns a 3-bit encoder index back into an 8-LED pattern,
// either as a direct one-hot or as a bar graph that fills in one LED per tick.
module code_to_led_decoder #(
  parameter int TICK_DIV = 5000000,
  parameter int CNT_W    = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       valid,
  input  logic       load,
  input  logic       mode,
  output logic [7:0] led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SWEEP, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic             load_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       step;
  logic [2:0]       code_r;
  logic             rise;

  assign rise = load & ~load_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      load_q <= 1'b0;
      cnt    <= '0;
      step   <= 3'd0;
      code_r <= 3'd0;
      led    <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      load_q <= load;
      done   <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (rise) begin
            if (!valid) begin
              led   <= 8'h00;
              state <= IDLE;
              done  <= 1'b1;
            end else if (!mode) begin
              code_r <= code;
              led    <= 8'h01 << code;
              state  <= SHOW;
              done   <= 1'b1;
            end else begin
              code_r <= code;
              led    <= 8'h01;
              step   <= 3'd0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= SWEEP;
            end
          end
        end
        SWEEP: begin
          // Load edges are deliberately ignored here; the sweep always runs to code_r.
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (step == code_r) begin
              state <= SHOW;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step <= step + 3'd1;
              led  <= {led[6:0], 1'b1};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
